branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/branch_sequencer.sv
// Branch sequencer: holds fetch while a branch resolves, waits out flag hazards,
// redirects the PC on taken branches and squashes the wrong-path fetch for FLUSH_CYCLES.
module branch_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iBranchValid,
  input  logic                  iUnconditional,
  input  logic [ADDR_WIDTH-1:0] iBranchTarget,
  input  logic                  iFlagsBusy,
  input  logic                  iBranchTaken,
  input  logic                  iStall,
  output logic                  oStallFetch,
  output logic                  oPCLoad,
  output logic [ADDR_WIDTH-1:0] oPCTarget,
  output logic                  oFlush,
  output logic                  oBusy,
  output logic [15:0]           oTakenCount
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FLAGS,
    DECIDE,
    REDIRECT,
    FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      flush_cnt   <= '0;
      oPCTarget   <= '0;
      oTakenCount <= '0;
    end else if (!iStall) begin
      unique case (state)
        IDLE: begin
          if (iBranchValid) begin
            oPCTarget <= iBranchTarget;
            if (iUnconditional)  state <= REDIRECT;
            else if (iFlagsBusy) state <= WAIT_FLAGS;
            else                 state <= DECIDE;
          end
        end
        WAIT_FLAGS: begin
          if (!iFlagsBusy) state <= DECIDE;
        end
        DECIDE: begin
          state <= iBranchTaken ? REDIRECT : IDLE;
        end
        REDIRECT: begin
          flush_cnt <= FLUSH_LOAD;
          state     <= (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
          if (oTakenCount != '1) oTakenCount <= oTakenCount + 16'd1;
        end
        FLUSH: begin
          // REDIRECT already supplied one flush cycle, so the count ends at 1
          if (flush_cnt <= 4'd1) begin
            state     <= IDLE;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pure decode of the state register; only the stall gate touches an input.
  assign oBusy       = (state != IDLE);
  assign oStallFetch = (state != IDLE);
  assign oPCLoad     = (state == REDIRECT) && !iStall;
  assign oFlush      = ((state == REDIRECT) || (state == FLUSH)) && !iStall;

endmodule
